// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - pipelined main control with load-use stall and branch flush
module pipe_control #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16,
    parameter bit EN_BNE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pcu_valid,
    input  logic [5:0]        i_pcu_opcode,
    input  logic [REG_AW-1:0] i_pcu_rs,
    input  logic [REG_AW-1:0] i_pcu_rt,
    input  logic              i_pcu_branch_taken,
    output logic              o_pcu_stall,
    output logic              o_pcu_flush,
    output logic              o_pcu_ex_valid,
    output logic              o_pcu_ex_regdst,
    output logic              o_pcu_ex_alusrc,
    output logic [1:0]        o_pcu_ex_aluop,
    output logic [REG_AW-1:0] o_pcu_ex_rt,
    output logic              o_pcu_mem_valid,
    output logic              o_pcu_mem_branch,
    output logic              o_pcu_mem_memread,
    output logic              o_pcu_mem_memwrite,
    output logic              o_pcu_wb_valid,
    output logic              o_pcu_wb_memtoreg,
    output logic              o_pcu_wb_regwrite,
    output logic              o_pcu_illegal,
    output logic [CNT_W-1:0]  o_pcu_stall_cnt
);

    logic       d_regdst, d_regwrite, d_alusrc, d_branch;
    logic       d_memread, d_memwrite, d_memtoreg, d_illegal;
    logic [1:0] d_aluop;

    always_comb begin
        d_regdst   = 1'b0;
        d_regwrite = 1'b0;
        d_alusrc   = 1'b0;
        d_branch   = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_aluop    = 2'b00;
        d_illegal  = 1'b0;
        casez (i_pcu_opcode)
            6'b001000, 6'b001001: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
            end
            6'b000000, 6'b011???: begin
                d_regdst   = 1'b1;
                d_regwrite = 1'b1;
                d_aluop    = 2'b10;
            end
            6'b0011??: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_aluop    = 2'b10;
            end
            6'b100???: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
            end
            6'b101???: begin
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
            end
            6'b000100: begin
                d_branch = 1'b1;
                d_aluop  = 2'b01;
            end
            6'b000101: begin
                if (EN_BNE) begin
                    d_branch = 1'b1;
                    d_aluop  = 2'b11;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            default: d_illegal = 1'b1;
        endcase
    end

    logic              ex_valid, ex_regdst, ex_alusrc, ex_branch, ex_memread;
    logic              ex_memwrite, ex_memtoreg, ex_regwrite, ex_illegal;
    logic [1:0]        ex_aluop;
    logic [REG_AW-1:0] ex_rt;
    logic              mem_valid, mem_branch, mem_memread, mem_memwrite;
    logic              mem_memtoreg, mem_regwrite;
    logic              wb_valid, wb_memtoreg, wb_regwrite;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use, flush, stall, id_load;

    // Writes to r0 are discarded, so a load targeting r0 creates no dependency.
    assign load_use = ex_valid & ex_memread & i_pcu_valid & (ex_rt != '0) &
                      ((ex_rt == i_pcu_rs) | (ex_rt == i_pcu_rt));
    assign flush    = mem_valid & mem_branch & i_pcu_branch_taken;
    assign stall    = load_use & ~flush;
    assign id_load  = i_pcu_valid & ~stall & ~flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid    <= 1'b0;
            ex_regdst   <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_illegal  <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_rt       <= '0;
        end else begin
            ex_valid    <= id_load;
            ex_regdst   <= id_load & d_regdst;
            ex_alusrc   <= id_load & d_alusrc;
            ex_branch   <= id_load & d_branch;
            ex_memread  <= id_load & d_memread;
            ex_memwrite <= id_load & d_memwrite;
            ex_memtoreg <= id_load & d_memtoreg;
            ex_regwrite <= id_load & d_regwrite;
            ex_illegal  <= id_load & d_illegal;
            ex_aluop    <= id_load ? d_aluop : 2'b00;
            ex_rt       <= id_load ? i_pcu_rt : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_valid    <= 1'b0;
            mem_branch   <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            wb_valid     <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
        end else begin
            mem_valid    <= ex_valid & ~flush;
            mem_branch   <= ex_branch & ~flush;
            mem_memread  <= ex_memread & ~flush;
            mem_memwrite <= ex_memwrite & ~flush;
            mem_memtoreg <= ex_memtoreg & ~flush;
            mem_regwrite <= ex_regwrite & ~flush;
            wb_valid     <= mem_valid;
            wb_memtoreg  <= mem_memtoreg;
            wb_regwrite  <= mem_regwrite;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign o_pcu_stall        = stall;
    assign o_pcu_flush        = flush;
    assign o_pcu_ex_valid     = ex_valid;
    assign o_pcu_ex_regdst    = ex_valid & ex_regdst;
    assign o_pcu_ex_alusrc    = ex_valid & ex_alusrc;
    assign o_pcu_ex_aluop     = ex_valid ? ex_aluop : 2'b00;
    assign o_pcu_ex_rt        = ex_valid ? ex_rt : '0;
    assign o_pcu_mem_valid    = mem_valid;
    assign o_pcu_mem_branch   = mem_valid & mem_branch;
    assign o_pcu_mem_memread  = mem_valid & mem_memread;
    assign o_pcu_mem_memwrite = mem_valid & mem_memwrite;
    assign o_pcu_wb_valid     = wb_valid;
    assign o_pcu_wb_memtoreg  = wb_valid & wb_memtoreg;
    assign o_pcu_wb_regwrite  = wb_valid & wb_regwrite;
    assign o_pcu_illegal      = ex_valid & ex_illegal;
    assign o_pcu_stall_cnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - scoreboard bench for pipe_control (default and CNT_W=2/EN_BNE=0 builds)
module tb_pipe_control;

    localparam int N = 0, ADDI = 1, ANDI = 2, R = 3, LW = 4, SW = 5, BEQ = 6, BNE = 7, ILL = 8;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_R = 6'b000000;
    localparam logic [5:0] OP_SPEC = 6'b011100, OP_LW = 6'b100011, OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ILL = 6'b111111;

    typedef struct packed {
        logic        stall, flush, ill;
        logic [9:0]  ex;
        logic [3:0]  mem;
        logic [2:0]  wb;
        logic [15:0] cnt;
        logic        stall2, flush2, ill2;
        logic [9:0]  ex2;
        logic [3:0]  mem2;
        logic [2:0]  wb2;
        logic [1:0]  cnt2;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_next = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [4:0] rs = 5'd0, rt = 5'd0;
    logic       taken = 1'b0;

    logic        stall, flush, ex_valid, ex_regdst, ex_alusrc, mem_valid, mem_branch;
    logic        mem_memread, mem_memwrite, wb_valid, wb_memtoreg, wb_regwrite, illegal;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rt;
    logic [15:0] stall_cnt;
    logic        stall2, flush2, ex_valid2, ex_regdst2, ex_alusrc2, mem_valid2, mem_branch2;
    logic        mem_memread2, mem_memwrite2, wb_valid2, wb_memtoreg2, wb_regwrite2, illegal2;
    logic [1:0]  ex_aluop2;
    logic [4:0]  ex_rt2;
    logic [1:0]  stall_cnt2;

    pipe_control u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pcu_valid(valid), .i_pcu_opcode(opcode),
        .i_pcu_rs(rs), .i_pcu_rt(rt), .i_pcu_branch_taken(taken),
        .o_pcu_stall(stall), .o_pcu_flush(flush), .o_pcu_ex_valid(ex_valid),
        .o_pcu_ex_regdst(ex_regdst), .o_pcu_ex_alusrc(ex_alusrc), .o_pcu_ex_aluop(ex_aluop),
        .o_pcu_ex_rt(ex_rt), .o_pcu_mem_valid(mem_valid), .o_pcu_mem_branch(mem_branch),
        .o_pcu_mem_memread(mem_memread), .o_pcu_mem_memwrite(mem_memwrite),
        .o_pcu_wb_valid(wb_valid), .o_pcu_wb_memtoreg(wb_memtoreg),
        .o_pcu_wb_regwrite(wb_regwrite), .o_pcu_illegal(illegal), .o_pcu_stall_cnt(stall_cnt)
    );

    pipe_control #(.CNT_W(2), .EN_BNE(1'b0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pcu_valid(valid), .i_pcu_opcode(opcode),
        .i_pcu_rs(rs), .i_pcu_rt(rt), .i_pcu_branch_taken(taken),
        .o_pcu_stall(stall2), .o_pcu_flush(flush2), .o_pcu_ex_valid(ex_valid2),
        .o_pcu_ex_regdst(ex_regdst2), .o_pcu_ex_alusrc(ex_alusrc2), .o_pcu_ex_aluop(ex_aluop2),
        .o_pcu_ex_rt(ex_rt2), .o_pcu_mem_valid(mem_valid2), .o_pcu_mem_branch(mem_branch2),
        .o_pcu_mem_memread(mem_memread2), .o_pcu_mem_memwrite(mem_memwrite2),
        .o_pcu_wb_valid(wb_valid2), .o_pcu_wb_memtoreg(wb_memtoreg2),
        .o_pcu_wb_regwrite(wb_regwrite2), .o_pcu_illegal(illegal2), .o_pcu_stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    obs_t sb[$];
    int   tags[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    // EX bundle: {valid, regdst, alusrc, aluop, rt}
    function automatic logic [9:0] exb(int k, logic [4:0] r);
        case (k)
            ADDI:    return {3'b101, 2'b00, r};
            ANDI:    return {3'b101, 2'b10, r};
            R:       return {3'b110, 2'b10, r};
            LW, SW:  return {3'b101, 2'b00, r};
            BEQ:     return {3'b100, 2'b01, r};
            BNE:     return {3'b100, 2'b11, r};
            ILL:     return {3'b100, 2'b00, r};
            default: return 10'd0;
        endcase
    endfunction

    // MEM bundle: {valid, branch, memread, memwrite}
    function automatic logic [3:0] memb(int k);
        case (k)
            ADDI, ANDI, R, ILL: return 4'b1000;
            LW:                 return 4'b1010;
            SW:                 return 4'b1001;
            BEQ, BNE:           return 4'b1100;
            default:            return 4'b0000;
        endcase
    endfunction

    // WB bundle: {valid, memtoreg, regwrite}
    function automatic logic [2:0] wbb(int k);
        case (k)
            ADDI, ANDI, R:      return 3'b101;
            LW:                 return 3'b111;
            SW, BEQ, BNE, ILL:  return 3'b100;
            default:            return 3'b000;
        endcase
    endfunction

    // The second build has bne disabled, so it sees bne as an illegal opcode.
    function automatic int k2(int k);
        return (k == BNE) ? ILL : k;
    endfunction

    task automatic step(input logic v, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic tk, input logic st, input logic fl,
                        input int ek, input logic [4:0] ert, input int mk, input int wk,
                        input logic [15:0] c, input logic [1:0] c2);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n  = rst_next;
        valid  = v;
        opcode = op;
        rs     = s;
        rt     = t;
        taken  = tk;
        e.stall  = st;
        e.flush  = fl;
        e.ill    = (ek == ILL);
        e.ex     = exb(ek, ert);
        e.mem    = memb(mk);
        e.wb     = wbb(wk);
        e.cnt    = c;
        e.stall2 = st;
        e.flush2 = fl;
        e.ill2   = (k2(ek) == ILL);
        e.ex2    = exb(k2(ek), ert);
        e.mem2   = memb(k2(mk));
        e.wb2    = wbb(k2(wk));
        e.cnt2   = c2;
        sb.push_back(e);
        tags.push_back(cyc);
        cyc++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            obs_t e, a;
            int   tg;
            e = sb.pop_front();
            tg = tags.pop_front();
            a.stall  = stall;
            a.flush  = flush;
            a.ill    = illegal;
            a.ex     = {ex_valid, ex_regdst, ex_alusrc, ex_aluop, ex_rt};
            a.mem    = {mem_valid, mem_branch, mem_memread, mem_memwrite};
            a.wb     = {wb_valid, wb_memtoreg, wb_regwrite};
            a.cnt    = stall_cnt;
            a.stall2 = stall2;
            a.flush2 = flush2;
            a.ill2   = illegal2;
            a.ex2    = {ex_valid2, ex_regdst2, ex_alusrc2, ex_aluop2, ex_rt2};
            a.mem2   = {mem_valid2, mem_branch2, mem_memread2, mem_memwrite2};
            a.wb2    = {wb_valid2, wb_memtoreg2, wb_regwrite2};
            a.cnt2   = stall_cnt2;
            checks++;
            if (a === e) passes++;
            else $display("FAIL step%0d actual=%h required=%h", tg, a, e);
        end
    end

    initial begin
        // Reset held: everything reads 0 even with a hazard-shaped input.
        step(1, OP_LW, 5, 5, 1,  0, 0, N, 0, N, N, 0, 0);
        step(1, OP_LW, 5, 5, 1,  0, 0, N, 0, N, N, 0, 0);
        rst_next = 1'b1;
        cyc = 0;
        step(1, OP_ADDI, 0, 1, 0, 0, 0, N,    0, N,    N,    0, 0);
        step(1, OP_R,    2, 3, 0, 0, 0, ADDI, 1, N,    N,    0, 0);
        step(1, OP_ANDI, 0, 4, 0, 0, 0, R,    3, ADDI, N,    0, 0);
        step(0, OP_R,    0, 0, 0, 0, 0, ANDI, 4, R,    ADDI, 0, 0);
        step(1, OP_LW,   0, 5, 0, 0, 0, N,    0, ANDI, R,    0, 0);
        step(1, OP_R,    5, 6, 0, 1, 0, LW,   5, N,    ANDI, 0, 0);
        step(1, OP_R,    5, 6, 0, 0, 0, N,    0, LW,   N,    1, 1);
        step(1, OP_LW,   0, 0, 0, 0, 0, R,    6, N,    LW,   1, 1);
        step(1, OP_SPEC, 0, 0, 0, 0, 0, LW,   0, R,    N,    1, 1);
        step(1, OP_SW,   1, 2, 0, 0, 0, R,    0, LW,   R,    1, 1);
        step(1, OP_BEQ,  1, 2, 0, 0, 0, SW,   2, R,    LW,   1, 1);
        step(1, OP_ADDI, 0, 7, 1, 0, 0, BEQ,  2, SW,   R,    1, 1);
        step(1, OP_R,    0, 8, 1, 0, 1, ADDI, 7, BEQ,  SW,   1, 1);
        step(0, OP_R,    0, 0, 1, 0, 0, N,    0, N,    BEQ,  1, 1);
        step(0, OP_R,    0, 0, 0, 0, 0, N,    0, N,    N,    1, 1);
        step(1, OP_BEQ,  0, 0, 0, 0, 0, N,    0, N,    N,    1, 1);
        step(1, OP_LB,   0, 9, 0, 0, 0, BEQ,  0, N,    N,    1, 1);
        step(1, OP_R,    9, 1, 1, 0, 1, LW,   9, BEQ,  N,    1, 1);
        step(0, OP_R,    0, 0, 0, 0, 0, N,    0, N,    BEQ,  1, 1);
        step(1, OP_ILL,  0, 4, 0, 0, 0, N,    0, N,    N,    1, 1);
        step(1, OP_BNE,  0, 3, 0, 0, 0, ILL,  4, N,    N,    1, 1);
        step(0, OP_R,    0, 0, 0, 0, 0, BNE,  3, ILL,  N,    1, 1);
        step(0, OP_R,    0, 0, 0, 0, 0, N,    0, BNE,  ILL,  1, 1);
        step(0, OP_R,    0, 0, 0, 0, 0, N,    0, N,    BNE,  1, 1);
        step(1, OP_LW,   0, 5, 0, 0, 0, N,    0, N,    N,    1, 1);
        step(1, OP_LW,   5, 5, 0, 1, 0, LW,   5, N,    N,    1, 1);
        step(1, OP_LW,   5, 5, 0, 0, 0, N,    0, LW,   N,    2, 2);
        step(1, OP_LW,   0, 5, 0, 1, 0, LW,   5, N,    LW,   2, 2);
        step(1, OP_LW,   0, 5, 0, 0, 0, N,    0, LW,   N,    3, 3);
        step(1, OP_R,    5, 0, 0, 1, 0, LW,   5, N,    LW,   3, 3);
        step(1, OP_R,    5, 0, 0, 0, 0, N,    0, LW,   N,    4, 3);
        step(0, OP_R,    0, 0, 0, 0, 0, R,    0, N,    LW,   4, 3);
        // Reset asserted between edges with live bundles in flight.
        step(1, OP_ADDI, 0, 7, 0, 0, 0, N,    0, N,    N,    0, 0);
        #2 rst_n = 1'b0;
        step(1, OP_ADDI, 0, 7, 0, 0, 0, N,    0, N,    N,    0, 0);
        step(0, OP_R,    0, 0, 0, 0, 0, ADDI, 7, N,    N,    0, 0);
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined main control unit for the ARC MIPS five-stage core. It decodes the ID-stage opcode into EX/MEM/WB control bundles and carries each bundle down ID/EX, EX/MEM and MEM/WB registers with per-stage valid bits. It also detects load-use hazards, which produce a one-cycle stall, and taken branches, which flush younger instructions. It sits between the IF/ID register and the datapath stage registers and replaces purely combinational decoding.

## Interface
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall counter.
- EN_BNE, 1, 1 = decode opcode 6'b000101 (bne); 0 = treat it as illegal.
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_pcu_valid  input  1  IF/ID holds a valid instruction.
- i_pcu_opcode  input  6  opcode of the ID instruction.
- i_pcu_rs, i_pcu_rt  input  REG_AW  source registers of the ID instruction.
- i_pcu_branch_taken  input  1  branch condition true for the MEM-stage instruction.
- o_pcu_stall  output  1  hold PC and IF/ID this cycle.
- o_pcu_flush  output  1  squash IF/ID contents this cycle.
- o_pcu_ex_valid, o_pcu_ex_regdst, o_pcu_ex_alusrc  output  1 each  EX bundle.
- o_pcu_ex_aluop  output  2  EX ALU operation class.
- o_pcu_ex_rt  output  REG_AW  rt of the EX instruction.
- o_pcu_mem_valid, o_pcu_mem_branch, o_pcu_mem_memread, o_pcu_mem_memwrite  output  1 each  MEM bundle.
- o_pcu_wb_valid, o_pcu_wb_memtoreg, o_pcu_wb_regwrite  output  1 each  WB bundle.
- o_pcu_illegal  output  1  one-cycle pulse: an illegal opcode entered EX.
- o_pcu_stall_cnt  output  CNT_W  count of stall cycles, saturating.

## Operation
- Decode is combinational in ID. Each row below gives regdst, regwrite, alusrc, branch, memread, memwrite, memtoreg, aluop.
  - 001000/001001 addi/addiu: 0,1,1,0,0,0,0,00.
  - 000000 R-type: 1,1,0,0,0,0,0,10.
  - 011??? special arithmetic: 1,1,0,0,0,0,0,10.
  - 0011?? andi/ori/xori/lui: 0,1,1,0,0,0,0,10.
  - 100??? loads: 0,1,1,0,1,0,1,00.
  - 101??? stores: 0,0,1,0,0,1,0,00 (memtoreg = 0).
  - 000100 beq: 0,0,0,1,0,0,0,01.
  - 000101 bne (EN_BNE=1 only): 0,0,0,1,0,0,0,11.
  - All other opcodes: illegal. Every control bit is 0 and the illegal flag is carried to EX.
- Any stage with valid = 0 drives every control output of that stage as 0.
- Load-use hazard: `load_use` = ex_valid & ex_memread & i_pcu_valid & (ex_rt != 0) & (ex_rt == i_pcu_rs | ex_rt == i_pcu_rt).
- Flush: `o_pcu_flush` = mem_valid & mem_branch & i_pcu_branch_taken.
- Stall: `o_pcu_stall` = load_use & ~o_pcu_flush. Flush has priority over stall.
- Register updates each clock edge:
  - ID/EX loads the decoded bundle with valid = i_pcu_valid. It loads a bubble (valid 0) when stall or flush is active.
  - EX/MEM loads ID/EX, or a bubble when flush is active.
  - MEM/WB always loads EX/MEM.
- `o_pcu_illegal` = ex_valid & ex_illegal.
- `o_pcu_stall_cnt` increments on every cycle with o_pcu_stall = 1 and holds at 2^CNT_W-1.

## Timing
- Reset (asynchronous, i_rst_n = 0): all valid bits, control bits, ex_rt, illegal and the counter go to 0. Outputs are 0 immediately, including o_pcu_stall and o_pcu_flush, because every valid is 0.
- Reset may assert mid-operation. In-flight bundles are discarded with no partial state. The first valid bundle reaches EX one edge after reset deassertion with i_pcu_valid = 1.
- Latency: an instruction in ID at cycle n has its EX bundle at n+1, MEM at n+2 and WB at n+3. Stall and flush add no extra latency to other instructions.
- o_pcu_stall and o_pcu_flush are combinational, valid in the same cycle as their cause, and must be sampled by the PC/IF-ID logic at the same edge.
- A load followed by a dependent instruction costs exactly one stall cycle. On the next cycle the load is in MEM, so load_use = 0.
- Simultaneous load_use and flush: flush only. The counter does not increment.
- Bubbles never trigger load_use, because ex_valid = 0.

## Test plan
- Reset then addi: opcode 001000, valid at cycle 0. At 1: ex_valid = 1, alusrc = 1, aluop = 00. At 3: wb_regwrite = 1, memtoreg = 0.
- Load-use: lw with rt = 5 in ID, then add with rs = 5. Stall = 1 for exactly one cycle. EX holds a bubble for that cycle. stall_cnt = 1. A dependency on rt = 0 gives no stall.
- beq with taken = 1 when beq is in MEM: flush = 1 for one cycle. The instructions then in EX and ID never reach MEM or EX with valid = 1. No regwrite is seen for them.
- Flush and load_use together: stall = 0, flush = 1, counter unchanged.
- Illegal opcode 111111 (and 000101 with EN_BNE = 0): illegal pulses for one cycle at n+1. All control outputs stay 0 through WB.
- CNT_W = 2 with four back-to-back hazards: counter reads 1, 2, 3, 3. i_rst_n low mid-sequence clears all outputs asynchronously.
